pll_rst_seq: RTL
================

PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 Parameter LOCK_STABLE_CYCLES, default 1024: number of cycles synchronized lock must stay high before reset release begins (min 1).
REQ-002 Parameter RELEASE_GAP, default 16: cycles between periph_rst deassertion and core_rst deassertion (min 1).
REQ-003 Parameter LOCK_TIMEOUT, default 65536: cycles spent waiting for lock before the PLL is re-reset (min 2).
REQ-004 Parameter PLL_RST_CYCLES, default 8: width of the PLL reset pulse in cycles (min 1).
REQ-005 clk  in  1  free-running board clock, i.e. the PLL input clock and never a PLL output; all logic is on its rising edge.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 lock  in  1  PLL lock indication, asynchronous to clk.
REQ-008 pll_rst  out  1  active-high reset request to the PLL rst pin.
REQ-009 periph_rst  out  1  active-high peripheral/bus reset, synchronous to clk.
REQ-010 core_rst  out  1  active-high CPU core reset, synchronous to clk.
REQ-011 ready  out  1  high while the sequencer is in RUN.
REQ-012 lock_lost_cnt  out  8  saturating count of lock losses that occur after reset release has begun.

Function
REQ-013 lock SHALL pass through a 2-flop synchronizer; lock_s is the second flop output, so lock_s is valid 2 edges after lock changes.
REQ-014 FSM states SHALL be WAIT_LOCK, PLL_RST, STABLE, REL_PERIPH and RUN; one shared counter cnt is cleared on every state change.
REQ-015 WAIT_LOCK: if lock_s=1, go to STABLE; otherwise increment cnt, and when cnt==LOCK_TIMEOUT-1, go to PLL_RST.
REQ-016 PLL_RST: increment cnt; when cnt==PLL_RST_CYCLES-1, go to WAIT_LOCK; lock_s is ignored in this state.
REQ-017 STABLE: if lock_s=0, go to WAIT_LOCK; otherwise increment cnt, and when cnt==LOCK_STABLE_CYCLES-1, go to REL_PERIPH.
REQ-018 REL_PERIPH: if lock_s=0, go to WAIT_LOCK; otherwise increment cnt, and when cnt==RELEASE_GAP-1, go to RUN.
REQ-019 RUN: if lock_s=0, go to WAIT_LOCK; otherwise hold.
REQ-020 Lock loss SHALL have priority over counter expiry when both occur in the same cycle.
REQ-021 Outputs SHALL be registered from next-state so that each output reflects the current state in the same cycle, glitch-free:
- pll_rst=1 only in PLL_RST;
- periph_rst=0 only in REL_PERIPH or RUN;
- core_rst=0 and ready=1 only in RUN.
REQ-022 A transition from REL_PERIPH or RUN to WAIT_LOCK SHALL increment lock_lost_cnt, saturating at 255 with no wrap.
REQ-023 cnt width SHALL be $clog2 of the largest parameter plus 1; cnt never wraps, because each state exits at its terminal count.
REQ-024 periph_rst SHALL always deassert strictly before core_rst, and core_rst SHALL always assert no later than periph_rst.

Reset
REQ-025 While rst=1, the block SHALL hold: state=WAIT_LOCK, cnt=0, both synchronizer flops=0, pll_rst=0, periph_rst=1, core_rst=1, ready=0, lock_lost_cnt=0.
REQ-026 rst asserted mid-sequence, including during PLL_RST, SHALL take effect on the next edge and SHALL truncate any pll_rst pulse in progress.

Structure
REQ-027 Package pll_rst_pkg SHALL hold the state enum and the default parameter constants.
REQ-028 The synchronizer SHALL be the sub-module sync_2ff: 1 bit, reset value 0, synchronous active-high reset.
REQ-029 The block SHALL be a single FSM plus counter, with no other sub-modules.

Verification (bench params: LOCK_STABLE_CYCLES=8, RELEASE_GAP=4, LOCK_TIMEOUT=64, PLL_RST_CYCLES=4)
REQ-030 Nominal: lock rises just before edge 0 -> STABLE at edge 2, periph_rst falls at edge 10, core_rst falls and ready rises at edge 14.
REQ-031 Timeout: lock held at 0 after rst release -> pll_rst high for exactly 4 cycles starting 64 cycles after release, and the pattern repeats every 68 cycles.
REQ-032 Glitch: lock high for 5 cycles, then low, during STABLE -> periph_rst stays 1, the FSM returns to WAIT_LOCK, and lock_lost_cnt stays 0.
REQ-033 Loss in RUN: drop lock -> periph_rst, core_rst=1 and ready=0 on the 3rd edge after the drop, and lock_lost_cnt=1; relock -> the full sequence repeats.
REQ-034 Saturation and reset: force 300 lock losses from RUN -> lock_lost_cnt=255; assert rst during PLL_RST -> pll_rst=0 on the next edge and all outputs match REQ-025.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
// The state enum and the counter-width helper live here so the top and bench agree.
package pll_rst_pkg;

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PLL_RST,
    STABLE,
    REL_PERIPH,
    RUN
  } state_e;

  localparam int unsigned LOCK_STABLE_CYCLES_DEF = 1024;
  localparam int unsigned RELEASE_GAP_DEF        = 16;
  localparam int unsigned LOCK_TIMEOUT_DEF       = 65536;
  localparam int unsigned PLL_RST_CYCLES_DEF     = 8;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
// Both stages clear on the synchronous active-high reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic stage_p0_q;
  logic stage_p1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_p0_q <= 1'b0;
      stage_p1_q <= 1'b0;
    end else begin
      stage_p0_q <= d;
      stage_p1_q <= stage_p0_q;
    end
  end

  assign q = stage_p1_q;

endmodule

// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: waits for a stable lock, then releases peripheral and core
// resets in order; re-pulses the PLL reset when lock never arrives.
module pll_rst_seq
  import pll_rst_pkg::*;
#(
  parameter int unsigned LOCK_STABLE_CYCLES = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned RELEASE_GAP        = RELEASE_GAP_DEF,
  parameter int unsigned LOCK_TIMEOUT       = LOCK_TIMEOUT_DEF,
  parameter int unsigned PLL_RST_CYCLES     = PLL_RST_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       lock,
  output logic       pll_rst,
  output logic       periph_rst,
  output logic       core_rst,
  output logic       ready,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned CNT_MAX = max4(LOCK_STABLE_CYCLES, RELEASE_GAP,
                                         LOCK_TIMEOUT, PLL_RST_CYCLES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX) + 1;

  localparam logic [CNT_W-1:0] LS_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RG_LAST = CNT_W'(RELEASE_GAP - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] PR_LAST = CNT_W'(PLL_RST_CYCLES - 1);

  logic             lock_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       lost_q, lost_d;
  logic             pll_rst_q, periph_rst_q, core_rst_q, ready_q;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (lock),
    .q   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    lost_d  = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s)                state_d = STABLE;
        else if (cnt_q == TO_LAST) state_d = PLL_RST;
      end
      PLL_RST: begin
        if (cnt_q == PR_LAST)      state_d = WAIT_LOCK;
      end
      STABLE: begin
        if (!lock_s)               state_d = WAIT_LOCK;
        else if (cnt_q == LS_LAST) state_d = REL_PERIPH;
      end
      REL_PERIPH: begin
        if (!lock_s)               state_d = WAIT_LOCK;
        else if (cnt_q == RG_LAST) state_d = RUN;
      end
      RUN: begin
        // RUN has no terminal count, so the counter parks instead of wrapping.
        cnt_d = cnt_q;
        if (!lock_s)               state_d = WAIT_LOCK;
      end
      default: state_d = WAIT_LOCK;
    endcase

    if (state_d != state_q) cnt_d = '0;

    if ((state_q == REL_PERIPH || state_q == RUN) && state_d == WAIT_LOCK &&
        lost_q != 8'hFF)
      lost_d = lost_q + 8'd1;
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      lost_q       <= 8'd0;
      pll_rst_q    <= 1'b0;
      periph_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lost_q       <= lost_d;
      pll_rst_q    <= (state_d == PLL_RST);
      periph_rst_q <= !(state_d == REL_PERIPH || state_d == RUN);
      core_rst_q   <= (state_d != RUN);
      ready_q      <= (state_d == RUN);
    end
  end

  assign pll_rst       = pll_rst_q;
  assign periph_rst    = periph_rst_q;
  assign core_rst      = core_rst_q;
  assign ready         = ready_q;
  assign lock_lost_cnt = lost_q;

endmodule
